// File: rtl/watchdog_reset_requester.sv
// Bus-mapped watchdog and software-reset initiator; drives a button-like active-low
// reset request and keeps the reset cause across the system reset it triggers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | watchdog disabled, waiting for EN 0->1 or a software reset
// S_ARMED | prescaler and timeout count running, kicks accepted
// S_PULSE | reset_req_n held low, bus writes ignored
module watchdog_reset_requester #(
   parameter int PRESCALE     = 25000,
   parameter int PULSE_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       reset_req_n
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(PULSE_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PULSE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   prescaler;
   logic [7:0]      count;
   logic [CW-1:0]   pulse_cnt;
   logic            en;
   logic [7:0]      reload;
   logic            wdt_cause, sw_cause;

   logic wr, wr_ctrl, wr_reload, wr_kick, wr_status;
   logic kick_reload, kick_sw, tick, expire, arm, disarm, pulse_done, wdt_set;
   logic armed_flag, pulsing_flag;

   // Writes are dropped while pulsing, W1C included.
   assign wr          = cs & we & (state != S_PULSE);
   assign wr_ctrl     = wr & (addr == 2'd0);
   assign wr_reload   = wr & (addr == 2'd1);
   assign wr_kick     = wr & (addr == 2'd2);
   assign wr_status   = wr & (addr == 2'd3);
   assign kick_reload = wr_kick & (data_in == 8'h5A);
   assign kick_sw     = wr_kick & (data_in == 8'hA5);
   assign tick        = (state == S_ARMED) & (prescaler == PW'(PRESCALE - 1));
   assign expire      = tick & (count == 8'd0);
   assign arm         = (state == S_IDLE) & wr_ctrl & data_in[0];
   assign disarm      = (state == S_ARMED) & wr_ctrl & ~data_in[0];
   assign pulse_done  = (state == S_PULSE) & (pulse_cnt == CW'(1));
   assign wdt_set     = expire & ~kick_sw & ~disarm & ~kick_reload;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (kick_sw)  state_nxt = S_PULSE;
            else if (arm) state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (kick_sw)      state_nxt = S_PULSE;
            else if (disarm)  state_nxt = S_IDLE;
            else if (wdt_set) state_nxt = S_PULSE;
         end
         S_PULSE: begin
            if (pulse_done) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      armed_flag   = (state == S_ARMED);
      pulsing_flag = (state == S_PULSE);
      data_out     = 8'h00;
      if (cs && !we) begin
         case (addr)
            2'd0:    data_out = {7'b0, en};
            2'd1:    data_out = reload;
            2'd3:    data_out = {4'b0, pulsing_flag, armed_flag, sw_cause, wdt_cause};
            default: data_out = 8'h00;
         endcase
      end
   end

   // Registered from the next state so the low level starts right after the trigger edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reset_req_n <= 1'b1;
      else        reset_req_n <= (state_nxt != S_PULSE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         count     <= 8'd0;
      end else if (arm || (state == S_ARMED && kick_reload)) begin
         prescaler <= '0;
         count     <= reload;
      end else if (state == S_ARMED) begin
         if (tick) begin
            prescaler <= '0;
            if (count != 8'd0) count <= count - 8'd1;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      pulse_cnt <= '0;
      else if (state != S_PULSE && state_nxt == S_PULSE) pulse_cnt <= CW'(PULSE_CYCLES);
      else if (state == S_PULSE)                        pulse_cnt <= pulse_cnt - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en        <= 1'b0;
         reload    <= 8'hFF;
         wdt_cause <= 1'b0;
         sw_cause  <= 1'b0;
      end else begin
         if (arm)                       en <= 1'b1;
         else if (disarm || pulse_done) en <= 1'b0;
         if (wr_reload) reload <= data_in;
         if (wdt_set)                        wdt_cause <= 1'b1;
         else if (wr_status && data_in[0])   wdt_cause <= 1'b0;
         if (kick_sw)                        sw_cause  <= 1'b1;
         else if (wr_status && data_in[1])   sw_cause  <= 1'b0;
      end
   end

endmodule
